// File: rtl/icache_fill_pkg.sv
// rtl/icache_fill_pkg.sv - shared word width, memory latency, FSM encoding and counter helper
//
// Purpose: common definitions imported by the instruction-cache fill logic,
//          its storage and the slow-memory side.
// Contents: WORD (bus width), MEMDELAY (nominal slowmem latency),
//           state_t (IDLE/REQ/WAIT), sat_inc (saturating counter step).
package icache_fill_pkg;

  localparam int WORD     = 16;
  localparam int MEMDELAY = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [WORD-1:0] sat_inc(input logic [WORD-1:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_fill_if.sv
// rtl/icache_fill_if.sv - processor/snoop/slowmem bundle for the instruction-cache fill block
//
// Purpose: groups every non-clock signal of icache_fill.
// Modports:
//   slave  - the cache: takes fetch/faddr, snoop/saddr, mfc/rdata;
//            drives instr/hit/busy, strobe/rnotw/maddr/wdata, hits/misses.
//   master - the environment (processor + slowmem), opposite directions.
interface icache_fill_if;
  import icache_fill_pkg::*;

  logic            fetch;
  logic [WORD-1:0] faddr;
  logic [WORD-1:0] instr;
  logic            hit;
  logic            busy;
  logic            snoop;
  logic [WORD-1:0] saddr;
  logic            strobe;
  logic            rnotw;
  logic [WORD-1:0] maddr;
  logic [WORD-1:0] wdata;
  logic            mfc;
  logic [WORD-1:0] rdata;
  logic [WORD-1:0] hits;
  logic [WORD-1:0] misses;

  modport slave (
    input  fetch, faddr, snoop, saddr, mfc, rdata,
    output instr, hit, busy, strobe, rnotw, maddr, wdata, hits, misses
  );

  modport master (
    output fetch, faddr, snoop, saddr, mfc, rdata,
    input  instr, hit, busy, strobe, rnotw, maddr, wdata, hits, misses
  );

endinterface

// File: rtl/icache_tagram.sv
// rtl/icache_tagram.sv - direct-mapped valid/tag/data store with read, fill and snoop-invalidate ports
//
// Purpose: one-word lines, LINES entries, index = low address bits.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset (clears valid bits)
//   i_rd_idx           - combinational read index
//   o_rd_valid/tag/data- contents of the indexed line
//   i_wr_en/idx/tag/data - fill write (sets valid)
//   i_inv_en/idx/tag   - snoop: clears valid if the line holds that tag
module icache_tagram
  import icache_fill_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDXW  = $clog2(LINES),
  parameter int TAGW  = WORD - IDXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic            o_rd_valid,
  output logic [TAGW-1:0] o_rd_tag,
  output logic [WORD-1:0] o_rd_data,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  logic [TAGW-1:0] i_wr_tag,
  input  logic [WORD-1:0] i_wr_data,
  input  logic            i_inv_en,
  input  logic [IDXW-1:0] i_inv_idx,
  input  logic [TAGW-1:0] i_inv_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag  [LINES];
  logic [WORD-1:0]  r_data [LINES];

  logic w_inv_hit;
  logic w_inv_wins;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

  // Snoop matches against pre-edge contents only.
  assign w_inv_hit = i_inv_en && r_valid[i_inv_idx] && (r_tag[i_inv_idx] == i_inv_tag);

  // Fill and snoop on the same line: equal index plus equal tag means the
  // store hit the very address being filled, and slowmem already forwarded
  // that store data on rdata, so the fill stands. Otherwise the snoop wins.
  assign w_inv_wins = w_inv_hit &&
                      !(i_wr_en && (i_wr_idx == i_inv_idx) && (i_wr_tag == i_inv_tag));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else begin
      if (i_wr_en)    r_valid[i_wr_idx]  <= 1'b1;
      if (w_inv_wins) r_valid[i_inv_idx] <= 1'b0;
    end
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - instruction-cache miss-fill FSM with hit/miss counters
//
// Purpose: direct-mapped one-word-line instruction cache; on a miss issues one
//          read strobe to slowmem and installs the word returned with mfc.
// Ports:
//   clk    - sole clock
//   reset  - asynchronous active-low reset
//   bus    - icache_fill_if.slave: fetch/faddr -> instr/hit, busy,
//            snoop/saddr invalidation, strobe/rnotw/maddr/wdata <- mfc/rdata,
//            hits/misses saturating counters
// Parameters: LINES (power of two, 2..256), MEMDELAY (expected slowmem latency,
//             checked by a simulation-only assertion).
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int MEMDELAY = icache_fill_pkg::MEMDELAY
) (
  input logic          clk,
  input logic          reset,
  icache_fill_if.slave bus
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = WORD - IDXW;

  state_t          r_state;
  logic [WORD-1:0] r_miss_addr;
  logic            r_strobe;
  logic            r_busy;
  logic [WORD-1:0] r_hits;
  logic [WORD-1:0] r_misses;
  logic [7:0]      r_wait_cnt;

  logic            w_rd_valid;
  logic [TAGW-1:0] w_rd_tag;
  logic [WORD-1:0] w_rd_data;
  logic            w_hit;
  logic            w_fill;

  icache_tagram #(
    .LINES (LINES),
    .IDXW  (IDXW),
    .TAGW  (TAGW)
  ) u_tagram (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (bus.faddr[IDXW-1:0]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_idx   (r_miss_addr[IDXW-1:0]),
    .i_wr_tag   (r_miss_addr[WORD-1:IDXW]),
    .i_wr_data  (bus.rdata),
    .i_inv_en   (bus.snoop),
    .i_inv_idx  (bus.saddr[IDXW-1:0]),
    .i_inv_tag  (bus.saddr[WORD-1:IDXW])
  );

  // Hit is reported in every state; only IDLE acts on it.
  assign w_hit  = bus.fetch && w_rd_valid && (w_rd_tag == bus.faddr[WORD-1:IDXW]);
  // mfc outside WAIT (e.g. a response to a fill abandoned by reset) is dropped.
  assign w_fill = (r_state == ST_WAIT) && bus.mfc;

  assign bus.hit    = w_hit;
  assign bus.instr  = w_rd_data;
  assign bus.busy   = r_busy;
  assign bus.strobe = r_strobe;
  assign bus.rnotw  = 1'b1;
  assign bus.maddr  = r_miss_addr;
  assign bus.wdata  = '0;
  assign bus.hits   = r_hits;
  assign bus.misses = r_misses;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_miss_addr <= '0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.fetch) begin
            if (w_hit) begin
              r_hits <= sat_inc(r_hits);
            end else begin
              // faddr is captured here so later changes cannot disturb the fill.
              r_miss_addr <= bus.faddr;
              r_strobe    <= 1'b1;
              r_busy      <= 1'b1;
              r_misses    <= sat_inc(r_misses);
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          r_strobe   <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mfc) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_strobe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe occupies one cycle, so mfc should land after MEMDELAY-1 WAIT cycles.
  always_ff @(posedge clk) begin
    if (reset && w_fill) begin
      assert (r_wait_cnt == 8'(MEMDELAY - 1));
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - scoreboard bench for icache_fill with a slowmem responder
module tb_icache_fill;
  import icache_fill_pkg::*;

  localparam int LINES = 16;
  localparam int MDLY  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  icache_fill_if bus();

  icache_fill #(
    .LINES    (LINES),
    .MEMDELAY (MDLY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_mfc  = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h3C3C;
  endfunction

  // slowmem: strobe seen in cycle n -> mfc with data in cycle n+MDLY
  initial begin
    logic [15:0] a;
    bus.mfc   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.strobe === 1'b1) begin
        a = bus.maddr;
        repeat (MDLY) @(negedge clk);
        bus.mfc   = 1'b1;
        bus.rdata = mem_rd(a);
        n_mfc++;
        @(negedge clk);
        bus.mfc   = 1'b0;
        bus.rdata = '0;
      end
    end
  end

  // Holds fetch until hit, then one more edge so the hit is counted.
  // Optional one-cycle snoop store in cycle snp_cyc (relative to fetch start).
  task automatic do_fetch(input logic [15:0] a, input int exp_strobes, input int exp_hit_cyc,
                          input int snp_cyc, input logic [15:0] snp_a, input logic [15:0] snp_d);
    int hit_cyc;
    int n_strobe;
    int first_strobe;
    logic [15:0] exp_w;
    exp_w = (snp_cyc >= 0 && snp_a == a) ? snp_d : mem_rd(a);
    sb_q.push_back(exp_w);
    hit_cyc = -1; n_strobe = 0; first_strobe = -1;
    @(negedge clk);
    bus.fetch = 1'b1;
    bus.faddr = a;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      bus.snoop = (c == snp_cyc);
      bus.saddr = snp_a;
      if (c == snp_cyc) mem[snp_a] = snp_d;
      #1;
      if (bus.strobe === 1'b1) begin
        n_strobe++;
        if (first_strobe < 0) begin
          first_strobe = c;
          chk("maddr", bus.maddr, a);
          chk("rnotw", bus.rnotw, 1);
          chk("busy_fill", bus.busy, 1);
        end
      end
      if (bus.hit === 1'b1) begin
        hit_cyc = c;
        break;
      end
    end
    bus.snoop = 1'b0;
    exp_w = sb_q.pop_front();
    if (hit_cyc < 0) chk("fill_timeout", 0, 1);
    else chk("instr", bus.instr, exp_w);
    chk("hit_cycle", hit_cyc, exp_hit_cyc);
    chk("strobes", n_strobe, exp_strobes);
    if (exp_strobes > 0) chk("strobe_cycle", first_strobe, 1);
    @(negedge clk);
    bus.fetch = 1'b0;
    #1;
  endtask

  task automatic do_snoop(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.snoop = 1'b1;
    bus.saddr = a;
    mem[a] = d;
    @(negedge clk);
    bus.snoop = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int mfc0;
    bus.fetch = 1'b0; bus.faddr = '0; bus.snoop = 1'b0; bus.saddr = '0;
    mem[16'h0005] = 16'hA123;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    bus.fetch = 1'b1; bus.faddr = 16'h0005;
    #1;
    chk("rst_hit",    bus.hit, 0);
    chk("rst_strobe", bus.strobe, 0);
    chk("rst_rnotw",  bus.rnotw, 1);
    chk("rst_maddr",  bus.maddr, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_hits",   bus.hits, 0);
    chk("rst_misses", bus.misses, 0);
    bus.fetch = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // cold miss, then repeated hits
    do_fetch(16'h0005, 1, MDLY + 2, -1, 16'h0, 16'h0);
    chk("misses_cold", bus.misses, 1);
    chk("hits_cold",   bus.hits, 1);
    do_fetch(16'h0005, 0, 0, -1, 16'h0, 16'h0);
    do_fetch(16'h0005, 0, 0, -1, 16'h0, 16'h0);
    chk("hits_repeat", bus.hits, 3);
    chk("misses_repeat", bus.misses, 1);

    // conflict on index 5
    do_fetch(16'h0015, 1, MDLY + 2, -1, 16'h0, 16'h0);
    do_fetch(16'h0005, 1, MDLY + 2, -1, 16'h0, 16'h0);
    chk("misses_conflict", bus.misses, 3);

    // snoop: other tag leaves line, matching tag invalidates
    do_snoop(16'h0015, 16'h7777);
    do_fetch(16'h0005, 0, 0, -1, 16'h0, 16'h0);
    do_snoop(16'h0005, 16'h1111);
    do_fetch(16'h0005, 1, MDLY + 2, -1, 16'h0, 16'h0);

    // store to the pending address during WAIT is forwarded and installed
    do_fetch(16'h0027, 1, MDLY + 2, 2, 16'h0027, 16'hBEEF);
    do_fetch(16'h0027, 0, 0, -1, 16'h0, 16'h0);

    // snoop to the resident address in the mfc cycle of a different-tag fill
    // wins: line stays invalid, held fetch misses again
    do_fetch(16'h0015, 2, 2 * (MDLY + 2), MDLY + 1, 16'h0005, 16'h2222);
    chk("hits_total",   bus.hits, 10);
    chk("misses_total", bus.misses, 7);

    // reset during WAIT; the late mfc must be ignored
    mfc0 = n_mfc;
    @(negedge clk);
    bus.fetch = 1'b1; bus.faddr = 16'h0033;
    @(negedge clk);
    bus.fetch = 1'b0;
    #1 chk("rw_strobe", bus.strobe, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_busy_async",   bus.busy, 0);
    chk("rw_strobe_async", bus.strobe, 0);
    chk("rw_hits",         bus.hits, 0);
    chk("rw_misses",       bus.misses, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rw_mfc_seen", n_mfc, mfc0 + 1);
    chk("rw_busy_idle", bus.busy, 0);
    bus.fetch = 1'b1; bus.faddr = 16'h0033;
    #1 chk("rw_hit_0033", bus.hit, 0);
    bus.faddr = 16'h0027;
    #1 chk("rw_hit_0027", bus.hit, 0);
    bus.fetch = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_hits_end",   bus.hits, 0);
    chk("rw_misses_end", bus.misses, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
